// File: rtl/shift_arbiter_pkg.sv
// Common ALU definitions shared by the shifter datapath and its arbiter.
// Holds the shift op encodings and the request bundle carried into the shifter.
package shift_arbiter_pkg;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef struct packed {
        logic [1:0]  op;
        logic [4:0]  amt;
        logic [31:0] data;
    } shift_req_t;

endpackage

// File: rtl/shift_arbiter_shift_unit_32.sv
// Combinational 32-bit shifter built as five conditional stages (16/8/4/2/1).
// Left shifts zero-fill; right shifts fill with zero or bit 31 for sra.
module shift_unit_32
    import shift_arbiter_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [4:0]  amt,
    input  logic [31:0] data,
    output logic [31:0] result
);

    logic        left;
    logic        fill;
    logic [31:0] s16;
    logic [31:0] s8;
    logic [31:0] s4;
    logic [31:0] s2;
    logic [31:0] s1;

    assign left = (op == OP_SLL);
    assign fill = (op == OP_SRA) && data[31];

    assign s16 = !amt[4] ? data : (left ? {data[15:0], 16'b0} : {{16{fill}}, data[31:16]});
    assign s8  = !amt[3] ? s16  : (left ? {s16[23:0], 8'b0}   : {{8{fill}},  s16[31:8]});
    assign s4  = !amt[2] ? s8   : (left ? {s8[27:0], 4'b0}    : {{4{fill}},  s8[31:4]});
    assign s2  = !amt[1] ? s4   : (left ? {s4[29:0], 2'b0}    : {{2{fill}},  s4[31:2]});
    assign s1  = !amt[0] ? s2   : (left ? {s2[30:0], 1'b0}    : {fill,       s2[31:1]});

    assign result = (op == OP_PASS) ? data : s1;

endmodule

// File: rtl/shift_arbiter.sv
// Two requesters share one shifter; results return through a one-entry output register.
// Round-robin priority flips to the losing requester after every handshake.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int PRIO_RESET = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [4:0]  req0_amt,
    input  logic [31:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [4:0]  req1_amt,
    input  logic [31:0] req1_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_id,
    output logic        prio
);

    // Handshakes: a transfer happens on any edge where valid && ready are both high.
    // Requesters hold valid and payload until ready; readies never look at their own
    // valid except through the grant, and the result register holds until res_ready.

    localparam logic PRIO_RESET_BIT = (PRIO_RESET != 0);

    logic       accept;
    logic       grant0;
    logic       grant1;
    logic       hs0;
    logic       hs1;
    shift_req_t sel_req;
    logic [31:0] shift_result;

    assign accept = !res_valid || res_ready;
    assign grant0 = req0_valid && (!req1_valid || !prio);
    assign grant1 = req1_valid && (!req0_valid || prio);

    // reset_n gates the readies so nothing can be accepted while reset is held.
    assign req0_ready = reset_n && accept && grant0;
    assign req1_ready = reset_n && accept && grant1;

    assign hs0 = req0_valid && req0_ready;
    assign hs1 = req1_valid && req1_ready;

    always_comb begin
        sel_req = '0;
        if (grant1) begin
            sel_req = '{op: req1_op, amt: req1_amt, data: req1_data};
        end else begin
            sel_req = '{op: req0_op, amt: req0_amt, data: req0_data};
        end
    end

    shift_unit_32 u_shift (
        .op     (sel_req.op),
        .amt    (sel_req.amt),
        .data   (sel_req.data),
        .result (shift_result)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= 1'b0;
            prio      <= PRIO_RESET_BIT;
        end else if (hs0 || hs1) begin
            res_valid <= 1'b1;
            res_data  <= shift_result;
            res_id    <= hs1;
            prio      <= hs0;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized bench for shift_arbiter: a queue-level reference model predicts grants
// and results, and an independent monitor checks every consumed result.
module tb_shift_arbiter;

    logic        clock;
    logic        reset_n;
    logic        req0_valid;
    logic        req0_ready;
    logic [1:0]  req0_op;
    logic [4:0]  req0_amt;
    logic [31:0] req0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [1:0]  req1_op;
    logic [4:0]  req1_amt;
    logic [31:0] req1_data;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_id;
    logic        prio;

    int checks = 0;
    int failures = 0;

    logic [38:0] rq0[$];
    logic [38:0] rq1[$];
    logic        present0 = 1'b0;
    logic        present1 = 1'b0;
    logic [32:0] exp_q[$];
    logic        prio_m = 1'b0;
    logic        full_m = 1'b0;
    logic        mon_en = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] held_data;
    logic        held_id;

    shift_arbiter #(.PRIO_RESET(0)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_amt   (req0_amt),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_amt   (req1_amt),
        .req1_data  (req1_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .prio       (prio)
    );

    // clock/reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [4:0] amt,
                                              input logic [31:0] d);
        case (op)
            2'd0:    return d << amt;
            2'd1:    return d >> amt;
            2'd2:    return 32'($signed(d) >>> amt);
            default: return d;
        endcase
    endfunction

    function automatic logic [38:0] rand_op();
        logic [4:0] amt;
        case ($urandom_range(0, 3))
            0:       amt = 5'd0;
            1:       amt = 5'd31;
            default: amt = 5'($urandom_range(0, 31));
        endcase
        return {2'($urandom_range(0, 3)), amt, 32'($urandom)};
    endfunction

    // driver tasks
    task automatic drive(input int rr_pct, input int v_pct);
        if (!present0 && rq0.size() > 0 && $urandom_range(0, 99) < v_pct) present0 = 1'b1;
        if (!present1 && rq1.size() > 0 && $urandom_range(0, 99) < v_pct) present1 = 1'b1;
        req0_valid = present0;
        req1_valid = present1;
        {req0_op, req0_amt, req0_data} = present0 ? rq0[0] : 39'($urandom);
        {req1_op, req1_amt, req1_data} = present1 ? rq1[0] : 39'($urandom);
        res_ready = ($urandom_range(0, 99) < rr_pct);
    endtask

    // Reference arbitration evaluated on stable inputs; a predicted handshake
    // lands in the result register at the following rising edge.
    task automatic model_step();
        logic accept_m;
        logic g;
        logic [38:0] head;
        accept_m = !full_m || res_ready;
        check("res_valid", res_valid, full_m);
        check("prio", prio, prio_m);
        g = (req0_valid && req1_valid) ? prio_m : req1_valid;
        check("req0_ready", req0_ready, accept_m && req0_valid && !g);
        check("req1_ready", req1_ready, accept_m && req1_valid && g);
        if (accept_m && (req0_valid || req1_valid)) begin
            if (g) begin
                head = rq1.pop_front();
                present1 = 1'b0;
            end else begin
                head = rq0.pop_front();
                present0 = 1'b0;
            end
            exp_q.push_back({g, ref_shift(head[38:37], head[36:32], head[31:0])});
            prio_m = !g;
            full_m = 1'b1;
        end else if (res_ready) begin
            full_m = 1'b0;
        end
    endtask

    task automatic run_cycles(input int n, input int rr_pct, input int v_pct);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            drive(rr_pct, v_pct);
            @(negedge clock);
            model_step();
        end
    endtask

    task automatic drain();
        int  budget;
        logic busy;
        budget = 0;
        busy = 1'b1;
        while (busy && budget < 300) begin
            run_cycles(1, 100, 100);
            budget++;
            busy = (rq0.size() != 0) || (rq1.size() != 0) || (exp_q.size() != 0) || full_m;
        end
        check("drain_done", busy, 1'b0);
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        logic [32:0] e;
        if (mon_en && reset_n) begin
            if (stall_prev) begin
                check("hold_data", res_data, held_data);
                check("hold_id", res_id, held_id);
            end
            if (res_valid && res_ready) begin
                check("result_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("res_id", res_id, e[32]);
                    check("res_data", res_data, e[31:0]);
                end
            end
            stall_prev = res_valid && !res_ready;
            held_data  = res_data;
            held_id    = res_id;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        reset_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        {req0_op, req0_amt, req0_data} = '0;
        {req1_op, req1_amt, req1_data} = '0;
        res_ready = 1'b1;
        #12;
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_res_data", res_data, 32'h0);
        check("rst_res_id", res_id, 1'b0);
        check("rst_prio", prio, 1'b0);
        check("rst_req0_ready", req0_ready, 1'b0);
        check("rst_req1_ready", req1_ready, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        mon_en = 1'b1;

        // contention from reset priority: ids alternate 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            rq0.push_back(rand_op());
            rq1.push_back(rand_op());
        end
        run_cycles(8, 100, 100);
        drain();

        // single sra and op coverage
        rq0.push_back({2'b10, 5'd4, 32'h8000_0000});
        drain();
        rq1.push_back({2'b01, 5'd31, 32'hFFFF_FFFF});
        drain();
        rq0.push_back({2'b00, 5'd0, 32'h1234_5678});
        rq1.push_back({2'b11, 5'd7, 32'hCAFE_F00D});
        drain();

        // backpressure: result pending, consumer stalls three cycles
        for (int i = 0; i < 2; i++) begin
            rq0.push_back(rand_op());
            rq1.push_back(rand_op());
        end
        run_cycles(1, 100, 100);
        run_cycles(3, 0, 100);
        drain();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if (rq0.size() < 3) rq0.push_back(rand_op());
            if (rq1.size() < 3) rq1.push_back(rand_op());
            run_cycles(1, 70, 70);
        end
        drain();

        // reset while a result is pending
        for (int i = 0; i < 3; i++) begin
            rq0.push_back(rand_op());
            rq1.push_back(rand_op());
        end
        run_cycles(1, 100, 100);
        run_cycles(1, 0, 100);
        check("pre_reset_valid", res_valid, 1'b1);
        @(posedge clock);
        #3;
        mon_en = 1'b0;
        reset_n = 1'b0;
        #1;
        check("mid_rst_res_valid", res_valid, 1'b0);
        check("mid_rst_req0_ready", req0_ready, 1'b0);
        check("mid_rst_req1_ready", req1_ready, 1'b0);
        check("mid_rst_prio", prio, 1'b0);
        exp_q.delete();
        full_m = 1'b0;
        prio_m = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        present0 = 1'b0;
        present1 = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        mon_en = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
